// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
// Signal bundle linking two data-memory requesters and the shared RAM port to the arbiter.
// The master view is the environment: both requesters plus the RAM read-data return.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 32
);
   logic          c0_req;
   logic          c0_lock;
   logic [AW-1:0] c0_addr;
   logic [3:0]    c0_wmask;
   logic [31:0]   c0_wdata;
   logic          c0_gnt;
   logic          c0_rvalid;
   logic [31:0]   c0_rdata;

   logic          c1_req;
   logic          c1_lock;
   logic [AW-1:0] c1_addr;
   logic [3:0]    c1_wmask;
   logic [31:0]   c1_wdata;
   logic          c1_gnt;
   logic          c1_rvalid;
   logic [31:0]   c1_rdata;

   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_wmask;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_data;

   modport slave (
      input  c0_req, c0_lock, c0_addr, c0_wmask, c0_wdata,
      input  c1_req, c1_lock, c1_addr, c1_wmask, c1_wdata,
      input  mem_data,
      output c0_gnt, c0_rvalid, c0_rdata,
      output c1_gnt, c1_rvalid, c1_rdata,
      output mem_addr, mem_wmask, mem_wdata
   );

   modport master (
      output c0_req, c0_lock, c0_addr, c0_wmask, c0_wdata,
      output c1_req, c1_lock, c1_addr, c1_wmask, c1_wdata,
      output mem_data,
      input  c0_gnt, c0_rvalid, c0_rdata,
      input  c1_gnt, c1_rvalid, c1_rdata,
      input  mem_addr, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Two-port arbiter for a single data-RAM port: round-robin or fixed priority, with an
// ownership lock for atomic multi-beat sequences and a one-cycle tagged read response.
module dmem_arbiter #(
   parameter int unsigned PRIO_MODE = 0,
   parameter int unsigned AW        = 32
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);
   logic last_gnt_q, last_gnt_d;
   logic lock_valid_q, lock_valid_d;
   logic lock_owner_q, lock_owner_d;
   logic rsp_pend_q, rsp_pend_d;
   logic rsp_port_q, rsp_port_d;

   logic gnt0, gnt1, gnt_any, gnt_port, gnt_lock, owner_req;

   assign owner_req = lock_owner_q ? bus.c1_req : bus.c0_req;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (lock_valid_q && owner_req) begin
         gnt0 = ~lock_owner_q;
         gnt1 = lock_owner_q;
      end else if (bus.c0_req && bus.c1_req) begin
         // Round-robin hands a tie to whichever port did not win last time.
         if (PRIO_MODE == 1 || last_gnt_q) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end else begin
         gnt0 = bus.c0_req;
         gnt1 = bus.c1_req;
      end
   end

   assign gnt_any  = gnt0 | gnt1;
   assign gnt_port = gnt1;
   assign gnt_lock = gnt1 ? bus.c1_lock : bus.c0_lock;

   always_comb begin
      bus.mem_addr  = {AW{1'b0}};
      bus.mem_wmask = 4'h0;
      bus.mem_wdata = 32'h0;
      if (gnt0) begin
         bus.mem_addr  = bus.c0_addr;
         bus.mem_wmask = bus.c0_wmask;
         bus.mem_wdata = bus.c0_wdata;
      end else if (gnt1) begin
         bus.mem_addr  = bus.c1_addr;
         bus.mem_wmask = bus.c1_wmask;
         bus.mem_wdata = bus.c1_wdata;
      end
   end

   assign bus.c0_gnt    = gnt0;
   assign bus.c1_gnt    = gnt1;
   assign bus.c0_rvalid = rsp_pend_q & ~rsp_port_q;
   assign bus.c1_rvalid = rsp_pend_q & rsp_port_q;
   assign bus.c0_rdata  = bus.mem_data;
   assign bus.c1_rdata  = bus.mem_data;

   always_comb begin
      last_gnt_d   = last_gnt_q;
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      rsp_pend_d   = gnt_any;
      rsp_port_d   = rsp_port_q;
      if (gnt_any) begin
         last_gnt_d   = gnt_port;
         rsp_port_d   = gnt_port;
         lock_valid_d = gnt_lock;
         lock_owner_d = gnt_port;
      end else if (lock_valid_q && !owner_req) begin
         lock_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt_q   <= 1'b1;
         lock_valid_q <= 1'b0;
         lock_owner_q <= 1'b0;
         rsp_pend_q   <= 1'b0;
         rsp_port_q   <= 1'b0;
      end else begin
         last_gnt_q   <= last_gnt_d;
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
         rsp_pend_q   <= rsp_pend_d;
         rsp_port_q   <= rsp_port_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share one stimulus
// stream, each with its own RAM; directed scenarios plus a randomized model comparison.
module tb_dmem_arbiter;
   localparam int unsigned AW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW)) bus_rr ();
   dmem_arbiter_if #(.AW(AW)) bus_fp ();

   dmem_arbiter #(.PRIO_MODE(0), .AW(AW)) u_rr (.clk(clk), .reset(reset), .bus(bus_rr));
   dmem_arbiter #(.PRIO_MODE(1), .AW(AW)) u_fp (.clk(clk), .reset(reset), .bus(bus_fp));

   logic          req_v  [2];
   logic          lock_v [2];
   logic [AW-1:0] addr_v [2];
   logic [3:0]    wm_v   [2];
   logic [31:0]   wd_v   [2];

   assign bus_rr.c0_req = req_v[0];  assign bus_fp.c0_req = req_v[0];
   assign bus_rr.c0_lock = lock_v[0]; assign bus_fp.c0_lock = lock_v[0];
   assign bus_rr.c0_addr = addr_v[0]; assign bus_fp.c0_addr = addr_v[0];
   assign bus_rr.c0_wmask = wm_v[0];  assign bus_fp.c0_wmask = wm_v[0];
   assign bus_rr.c0_wdata = wd_v[0];  assign bus_fp.c0_wdata = wd_v[0];
   assign bus_rr.c1_req = req_v[1];  assign bus_fp.c1_req = req_v[1];
   assign bus_rr.c1_lock = lock_v[1]; assign bus_fp.c1_lock = lock_v[1];
   assign bus_rr.c1_addr = addr_v[1]; assign bus_fp.c1_addr = addr_v[1];
   assign bus_rr.c1_wmask = wm_v[1];  assign bus_fp.c1_wmask = wm_v[1];
   assign bus_rr.c1_wdata = wd_v[1];  assign bus_fp.c1_wdata = wd_v[1];

   // RAM models: registered read of the old word, byte-masked write, plus a bench preload.
   logic [31:0] ram_rr [64];
   logic [31:0] ram_fp [64];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      bus_rr.mem_data <= ram_rr[bus_rr.mem_addr[5:0]];
      for (int b = 0; b < 4; b++)
         if (bus_rr.mem_wmask[b])
            ram_rr[bus_rr.mem_addr[5:0]][8*b +: 8] <= bus_rr.mem_wdata[8*b +: 8];
      if (pl_en) ram_rr[pl_addr] <= pl_data;
   end

   always @(posedge clk) begin
      bus_fp.mem_data <= ram_fp[bus_fp.mem_addr[5:0]];
      for (int b = 0; b < 4; b++)
         if (bus_fp.mem_wmask[b])
            ram_fp[bus_fp.mem_addr[5:0]][8*b +: 8] <= bus_fp.mem_wdata[8*b +: 8];
      if (pl_en) ram_fp[pl_addr] <= pl_data;
   end

   int passes = 0;
   int checks = 0;

   // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
   int          m_last [2];
   bit          m_lkv  [2];
   int          m_lko  [2];
   bit          m_pend [2];
   int          m_port [2];
   logic [31:0] m_rd   [2];
   logic [31:0] ref_mem [2][64];

   task automatic drive(input int p, input logic req, input logic lock,
                        input logic [AW-1:0] addr, input logic [3:0] wm, input logic [31:0] wd);
      req_v[p] = req; lock_v[p] = lock; addr_v[p] = addr; wm_v[p] = wm; wd_v[p] = wd;
   endtask

   task automatic idle();
      drive(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
   endtask

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic reset_dut();
      idle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_last[k] = 1; m_lkv[k] = 1'b0; m_lko[k] = 0; m_pend[k] = 1'b0; m_port[k] = 0;
      end
   endtask

   // Port chosen by the arbitration rules for instance k given current requests.
   function automatic int pick(input int k);
      if (m_lkv[k] && req_v[m_lko[k]]) return m_lko[k];
      if (req_v[0] && req_v[1]) return (k == 1) ? 0 : 1 - m_last[k];
      if (req_v[0]) return 0;
      if (req_v[1]) return 1;
      return -1;
   endfunction

   task automatic test_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus_rr.c0_rvalid, bus_rr.c1_rvalid, bus_fp.c0_rvalid, bus_fp.c1_rvalid} !== 4'b0000)
         $display("FAIL reset_rvalid got=%b want=0000", {bus_rr.c0_rvalid, bus_rr.c1_rvalid,
                  bus_fp.c0_rvalid, bus_fp.c1_rvalid});
      else passes++;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_rr.c0_gnt, bus_rr.c1_gnt, bus_rr.mem_addr, bus_rr.mem_wmask, bus_rr.mem_wdata}
          !== '0)
         $display("FAIL reset_idle_bus got gnt=%b%b addr=%h wm=%h wd=%h want all zero",
                  bus_rr.c0_gnt, bus_rr.c1_gnt, bus_rr.mem_addr, bus_rr.mem_wmask,
                  bus_rr.mem_wdata);
      else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_single_read();
      preload(6'd5, 32'hDEADBEEF);
      drive(0, 1'b1, 1'b0, 32'd5, 4'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus_rr.c0_gnt, bus_rr.c1_gnt, bus_fp.c0_gnt, bus_fp.c1_gnt} !== 4'b1010)
         $display("FAIL read_gnt got=%b want=1010", {bus_rr.c0_gnt, bus_rr.c1_gnt,
                  bus_fp.c0_gnt, bus_fp.c1_gnt});
      else passes++;
      checks++;
      if ({bus_rr.mem_addr, bus_rr.mem_wmask, bus_fp.mem_addr, bus_fp.mem_wmask}
          !== {32'd5, 4'h0, 32'd5, 4'h0})
         $display("FAIL read_mem got rr=%h/%h fp=%h/%h want 5/0", bus_rr.mem_addr,
                  bus_rr.mem_wmask, bus_fp.mem_addr, bus_fp.mem_wmask);
      else passes++;
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if ({bus_rr.c0_rvalid, bus_rr.c1_rvalid, bus_fp.c0_rvalid, bus_fp.c1_rvalid} !== 4'b1010)
         $display("FAIL read_rvalid got=%b want=1010", {bus_rr.c0_rvalid, bus_rr.c1_rvalid,
                  bus_fp.c0_rvalid, bus_fp.c1_rvalid});
      else passes++;
      checks++;
      if ({bus_rr.c0_rdata, bus_fp.c0_rdata} !== {2{32'hDEADBEEF}})
         $display("FAIL read_rdata got=%h/%h want=deadbeef", bus_rr.c0_rdata, bus_fp.c0_rdata);
      else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      logic [31:0] want;
      reset_dut();
      preload(6'd10, 32'hA0A0000A);
      preload(6'd20, 32'hB0B00014);
      drive(0, 1'b1, 1'b0, 32'd10, 4'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 32'd20, 4'h0, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({bus_rr.c0_gnt, bus_rr.c1_gnt, bus_rr.mem_addr} !==
             {(i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0) ? 32'd10 : 32'd20})
            $display("FAIL rr_gnt cycle=%0d got=%b%b addr=%0d", i, bus_rr.c0_gnt,
                     bus_rr.c1_gnt, bus_rr.mem_addr);
         else passes++;
         checks++;
         if ({bus_fp.c0_gnt, bus_fp.c1_gnt} !== 2'b10)
            $display("FAIL fp_tie_gnt cycle=%0d got=%b%b want=10", i, bus_fp.c0_gnt,
                     bus_fp.c1_gnt);
         else passes++;
         checks++;
         if ({bus_rr.c0_rvalid, bus_rr.c1_rvalid} !==
             ((i == 0) ? 2'b00 : ((i - 1) % 2 == 0) ? 2'b10 : 2'b01))
            $display("FAIL rr_rvalid cycle=%0d got=%b%b", i, bus_rr.c0_rvalid,
                     bus_rr.c1_rvalid);
         else passes++;
         if (i > 0) begin
            want = ((i - 1) % 2 == 0) ? 32'hA0A0000A : 32'hB0B00014;
            checks++;
            if ((((i - 1) % 2 == 0) ? bus_rr.c0_rdata : bus_rr.c1_rdata) !== want)
               $display("FAIL rr_rdata cycle=%0d got=%h want=%h", i, bus_rr.c0_rdata, want);
            else passes++;
         end
         @(posedge clk); #1;
      end
      idle();
   endtask

   task automatic test_fixed_priority();
      reset_dut();
      drive(0, 1'b1, 1'b0, 32'd10, 4'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 32'd20, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({bus_fp.c0_gnt, bus_fp.c1_gnt, bus_fp.c0_rvalid} !== {2'b10, i != 0})
            $display("FAIL fp_hold cycle=%0d got gnt=%b%b rv0=%b", i, bus_fp.c0_gnt,
                     bus_fp.c1_gnt, bus_fp.c0_rvalid);
         else passes++;
         @(posedge clk); #1;
      end
      drive(0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus_fp.c0_gnt, bus_fp.c1_gnt, bus_fp.mem_addr} !== {2'b01, 32'd20})
         $display("FAIL fp_c1_after_drop got=%b%b addr=%0d want=01 addr=20", bus_fp.c0_gnt,
                  bus_fp.c1_gnt, bus_fp.mem_addr);
      else passes++;
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if ({bus_fp.c0_rvalid, bus_fp.c1_rvalid, bus_fp.c1_rdata} !== {2'b01, 32'hB0B00014})
         $display("FAIL fp_c1_rsp got rv=%b%b rdata=%h want=01 b0b00014", bus_fp.c0_rvalid,
                  bus_fp.c1_rvalid, bus_fp.c1_rdata);
      else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_byte_write();
      preload(6'd3, 32'h11223344);
      drive(1, 1'b1, 1'b0, 32'd3, 4'b0010, 32'h0000AB00);
      @(negedge clk);
      checks++;
      if ({bus_rr.c1_gnt, bus_rr.mem_wmask, bus_rr.mem_wdata,
           bus_fp.c1_gnt, bus_fp.mem_wmask, bus_fp.mem_wdata}
          !== {2{1'b1, 4'b0010, 32'h0000AB00}})
         $display("FAIL bw_drive got rr=%b/%b/%h fp=%b/%b/%h", bus_rr.c1_gnt,
                  bus_rr.mem_wmask, bus_rr.mem_wdata, bus_fp.c1_gnt, bus_fp.mem_wmask,
                  bus_fp.mem_wdata);
      else passes++;
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b0, 32'd3, 4'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus_rr.c1_rvalid, bus_fp.c1_rvalid, bus_rr.c1_rdata, bus_fp.c1_rdata}
          !== {2'b11, {2{32'h11223344}}})
         $display("FAIL bw_ack got rv=%b%b rdata=%h/%h want=11 11223344", bus_rr.c1_rvalid,
                  bus_fp.c1_rvalid, bus_rr.c1_rdata, bus_fp.c1_rdata);
      else passes++;
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if ({bus_rr.c1_rvalid, bus_fp.c1_rvalid, bus_rr.c1_rdata, bus_fp.c1_rdata}
          !== {2'b11, {2{32'h1122AB44}}})
         $display("FAIL bw_readback got rv=%b%b rdata=%h/%h want=11 1122ab44",
                  bus_rr.c1_rvalid, bus_fp.c1_rvalid, bus_rr.c1_rdata, bus_fp.c1_rdata);
      else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_lock();
      logic [4:0] c0r = 5'b11110;
      logic [4:0] c1l = 5'b00111;
      logic [4:0] g1  = 5'b01111;
      reset_dut();
      for (int b = 0; b < 5; b++) begin
         drive(0, c0r[b], 1'b0, 32'd7, 4'h0, 32'h0);
         drive(1, 1'b1, c1l[b], 32'd8, 4'h0, 32'h0);
         @(negedge clk);
         checks++;
         if ({bus_rr.c0_gnt, bus_rr.c1_gnt, bus_fp.c0_gnt, bus_fp.c1_gnt}
             !== {2{~g1[b], g1[b]}})
            $display("FAIL lock_beat%0d got=%b%b%b%b want=%b%b%b%b", b, bus_rr.c0_gnt,
                     bus_rr.c1_gnt, bus_fp.c0_gnt, bus_fp.c1_gnt, ~g1[b], g1[b], ~g1[b], g1[b]);
         else passes++;
         @(posedge clk); #1;
      end
      idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight();
      drive(0, 1'b1, 1'b0, 32'd5, 4'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus_rr.c0_gnt, bus_fp.c0_gnt} !== 2'b11)
         $display("FAIL mid_gnt got=%b%b want=11", bus_rr.c0_gnt, bus_fp.c0_gnt);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if ({bus_rr.c0_rvalid, bus_fp.c0_rvalid} !== 2'b11)
         $display("FAIL mid_rvalid_before got=%b%b want=11", bus_rr.c0_rvalid,
                  bus_fp.c0_rvalid);
      else passes++;
      #1;
      reset = 1'b1;
      idle();
      #1;
      checks++;
      if ({bus_rr.c0_rvalid, bus_fp.c0_rvalid, bus_rr.mem_wmask, bus_fp.mem_wmask} !== '0)
         $display("FAIL mid_async_clear got rv=%b%b wm=%h/%h want all zero", bus_rr.c0_rvalid,
                  bus_fp.c0_rvalid, bus_rr.mem_wmask, bus_fp.mem_wmask);
      else passes++;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({bus_rr.c0_rvalid, bus_rr.c1_rvalid, bus_fp.c0_rvalid, bus_fp.c1_rvalid,
              bus_rr.mem_wmask, bus_fp.mem_wmask} !== '0)
            $display("FAIL mid_after_release cycle=%0d got rv=%b%b%b%b wm=%h/%h", i,
                     bus_rr.c0_rvalid, bus_rr.c1_rvalid, bus_fp.c0_rvalid, bus_fp.c1_rvalid,
                     bus_rr.mem_wmask, bus_fp.mem_wmask);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [1:0]      obs_gnt [2];
      logic [1:0]      obs_rv  [2];
      logic [AW+35:0]  obs_mem [2];
      logic [31:0]     obs_rd  [2][2];
      logic [1:0]      exp_gnt;
      logic [1:0]      exp_rv;
      logic [AW+35:0]  exp_mem;
      logic [31:0]     v;
      logic [5:0]      a;
      int              g;
      reset_dut();
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         preload(6'(i), v);
         ref_mem[0][i] = v;
         ref_mem[1][i] = v;
      end
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++)
            drive(p, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                  AW'($urandom_range(0, 63)),
                  ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom);
         @(negedge clk);
         obs_gnt[0] = {bus_rr.c0_gnt, bus_rr.c1_gnt};
         obs_gnt[1] = {bus_fp.c0_gnt, bus_fp.c1_gnt};
         obs_rv[0]  = {bus_rr.c0_rvalid, bus_rr.c1_rvalid};
         obs_rv[1]  = {bus_fp.c0_rvalid, bus_fp.c1_rvalid};
         obs_mem[0] = {bus_rr.mem_addr, bus_rr.mem_wmask, bus_rr.mem_wdata};
         obs_mem[1] = {bus_fp.mem_addr, bus_fp.mem_wmask, bus_fp.mem_wdata};
         obs_rd[0][0] = bus_rr.c0_rdata; obs_rd[0][1] = bus_rr.c1_rdata;
         obs_rd[1][0] = bus_fp.c0_rdata; obs_rd[1][1] = bus_fp.c1_rdata;
         for (int k = 0; k < 2; k++) begin
            g = pick(k);
            exp_gnt = (g == 0) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;
            exp_mem = (g < 0) ? '0 : {addr_v[g], wm_v[g], wd_v[g]};
            exp_rv  = !m_pend[k] ? 2'b00 : (m_port[k] == 0) ? 2'b10 : 2'b01;
            checks++;
            if (obs_gnt[k] !== exp_gnt)
               $display("FAIL rand_gnt inst=%0d cycle=%0d got=%b want=%b", k, n,
                        obs_gnt[k], exp_gnt);
            else passes++;
            checks++;
            if (obs_mem[k] !== exp_mem)
               $display("FAIL rand_mem inst=%0d cycle=%0d got=%h want=%h", k, n,
                        obs_mem[k], exp_mem);
            else passes++;
            checks++;
            if (obs_rv[k] !== exp_rv)
               $display("FAIL rand_rvalid inst=%0d cycle=%0d got=%b want=%b", k, n,
                        obs_rv[k], exp_rv);
            else passes++;
            if (m_pend[k]) begin
               checks++;
               if (obs_rd[k][m_port[k]] !== m_rd[k])
                  $display("FAIL rand_rdata inst=%0d cycle=%0d got=%h want=%h", k, n,
                           obs_rd[k][m_port[k]], m_rd[k]);
               else passes++;
            end
            if (g >= 0) begin
               a = addr_v[g][5:0];
               m_rd[k] = ref_mem[k][a];
               for (int b = 0; b < 4; b++)
                  if (wm_v[g][b]) ref_mem[k][a][8*b +: 8] = wd_v[g][8*b +: 8];
               m_pend[k] = 1'b1;
               m_port[k] = g;
               m_last[k] = g;
               m_lkv[k]  = lock_v[g];
               m_lko[k]  = g;
            end else begin
               m_pend[k] = 1'b0;
               if (m_lkv[k] && !req_v[m_lko[k]]) m_lkv[k] = 1'b0;
            end
         end
         @(posedge clk); #1;
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_byte_write();
      test_lock();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-RAM port (word-addressed, byte-masked write, 1-cycle registered read) between two requesters: port 0 = CPU load/store unit, port 1 = DMA/debug loader.
- Selects one requester per cycle, drives mem_addr/mem_wmask/mem_wdata, and returns the read data to the granted requester one cycle later, tagged by rvalid.
- Supports round-robin or fixed priority, plus a lock for atomic multi-beat sequences.

Parameters:
PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
AW, 32, address width of the requester and memory address buses (word address).

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
c0_req  in  1  port 0 access request; held until granted
c0_lock  in  1  port 0 requests to keep ownership after this grant
c0_addr  in  AW  port 0 word address
c0_wmask  in  4  port 0 byte write mask; 0 = read
c0_wdata  in  32  port 0 write data
c0_gnt  out  1  port 0 access accepted this cycle (combinational)
c0_rvalid  out  1  port 0 response valid (cycle after grant)
c0_rdata  out  32  port 0 read data, valid when c0_rvalid
c1_req, c1_lock, c1_addr, c1_wmask, c1_wdata, c1_gnt, c1_rvalid, c1_rdata  same as port 0, for port 1
mem_addr  out  AW  RAM word address
mem_wmask  out  4  RAM byte write enables
mem_wdata  out  32  RAM write data
mem_data  in  32  RAM read data, registered by RAM, valid the cycle after the address

Behaviour:
- State: last_gnt (1 bit), lock_valid (1), lock_owner (1), rsp_pend (1), rsp_port (1).
- Reset (async, any time): last_gnt=1 (port 0 wins the first tie), lock_valid=0, rsp_pend=0, so c0_rvalid=c1_rvalid=0 immediately. A response in flight at reset is dropped. Gnt outputs follow the combinational rules from reset release.
- Grant selection (combinational, evaluated every cycle):
  1. If lock_valid and the owner asserts req: grant the owner; the other port waits even if requesting.
  2. Else if only one port requests: grant it.
  3. Else if both request: PRIO_MODE=1 grants port 0. PRIO_MODE=0 grants the port that is not last_gnt.
  4. Else: no grant.
- At most one gnt high per cycle. No grant while req is low.
- Memory drive: if port N is granted, mem_addr/mem_wmask/mem_wdata = cN_addr/cN_wmask/cN_wdata. If nothing is granted, mem_wmask=4'h0, mem_addr=0 and mem_wdata=0; there is never a spurious write.
- Throughput: one access per cycle, back-to-back, with no bubbles, including when ownership switches between ports.
- Response: on a grant edge, rsp_pend<=1 and rsp_port<=N; otherwise rsp_pend<=0.
  - cN_rvalid = rsp_pend && rsp_port==N.
  - c0_rdata = c1_rdata = mem_data, passed through unregistered.
  - rvalid is raised for writes too, acting as a write-complete acknowledge; rdata is then the pre-write word, because the RAM read port returns old data.
- last_gnt updates to N on every grant edge and holds when idle.
- Lock:
  - Set on a grant edge to port N with cN_lock=1: lock_valid<=1, lock_owner<=N.
  - Cleared on an edge where the owner is granted with cN_lock=0, or where the owner's req is low.
  - A lock taken while the other port is requesting is honoured; the other port is starved until release. Starvation prevention is not required.
- Simultaneous events: a grant with lock=0 while lock_valid releases the lock on that same edge, and the other port may win the next cycle. Requests arriving in the same cycle as release follow rule 3.
- Address/mask values on non-granted ports are ignored; no X-propagation onto mem_* when idle.

Test Plan:
1. Reset then single read: c0_req=1, c0_addr=5, c0_wmask=0, with RAM[5]=32'hDEADBEEF. Expect c0_gnt=1 in cycle 0, mem_addr=5 and mem_wmask=0. In cycle 1 expect c0_rvalid=1 and c0_rdata=32'hDEADBEEF, with c1_rvalid=0.
2. Round-robin (PRIO_MODE=0): both ports request continuously for 6 cycles, addresses 10 and 20. Expect grants 0,1,0,1,0,1 with no idle cycle, and rvalid alternating 0,1,... one cycle delayed with matching data.
3. Fixed priority (PRIO_MODE=1): both ports request for 4 cycles. Expect c0_gnt in all 4 and c1_gnt=0. c1 is granted in cycle 4, after c0_req drops.
4. Byte write: c1_req=1, c1_addr=3, c1_wmask=4'b0010, c1_wdata=32'h0000AB00, over old word 32'h11223344. Expect c1_rvalid next cycle. A later read of address 3 returns 32'h1122AB44.
5. Lock: c1 requests with lock=1 for 3 beats while c0 requests throughout. Expect c1_gnt for 3 cycles and c0 blocked. c1 then drops lock on beat 4 while still requesting; c0 is granted on beat 5.
6. Reset mid-flight: assert reset asynchronously in the cycle after a c0 grant. Expect c0_rvalid=0 immediately and no rvalid after release. mem_wmask=0 while no req is asserted.
